// File: rtl/animated_sprite_gen_if.sv
// ============================================================================
// Module      : animated_sprite_gen_if
// Description : Beam/position/animation-control inputs, sprite ROM address and
//               data, and colour outputs of the animated sprite renderer.
//               The hflip member exists only when SPRITE_HFLIP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface animated_sprite_gen_if #(
  parameter int SPRITE_SIZE = 16,
  parameter int FRAME_COUNT = 2
);
  localparam int c_CB = $clog2(SPRITE_SIZE);
  localparam int c_FB = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;

  logic [9:0]      shpos;
  logic [9:0]      svpos;
  logic [9:0]      xpos;
  logic [9:0]      ypos;
  logic            vsync;
  logic            anim_en;
  logic            anim_restart;
  logic            oneshot;
`ifdef SPRITE_HFLIP_EN
  logic            hflip;
`endif
  logic [c_FB-1:0] frame;
  logic [c_CB-1:0] yin;
  logic [c_CB-1:0] xin;
  logic            pixel;
  logic [2:0]      rgb;
  logic            active;
  logic            anim_done;

  modport master (
    output shpos, svpos, xpos, ypos, vsync, anim_en, anim_restart, oneshot,
`ifdef SPRITE_HFLIP_EN
    output hflip,
`endif
    output pixel,
    input  frame, yin, xin, rgb, active, anim_done
  );

  modport slave (
    input  shpos, svpos, xpos, ypos, vsync, anim_en, anim_restart, oneshot,
`ifdef SPRITE_HFLIP_EN
    input  hflip,
`endif
    input  pixel,
    output frame, yin, xin, rgb, active, anim_done
  );
endinterface

`default_nettype wire

// File: rtl/animated_sprite_gen.sv
// ============================================================================
// Module      : animated_sprite_gen
// Description : Two-stage animated sprite renderer with looping/one-shot frame
//               animation. Optional column mirror enabled by SPRITE_HFLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module animated_sprite_gen #(
  parameter int SPRITE_SIZE   = 16,
  parameter int FRAME_COUNT   = 2,
  parameter int FRAME_TIME    = 30,
  parameter int PRIMARY_COLOR = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  animated_sprite_gen_if.slave  sif
);
  localparam int c_CB = $clog2(SPRITE_SIZE);
  localparam int c_FB = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
  localparam int c_TW = (FRAME_TIME > 1) ? $clog2(FRAME_TIME) : 1;

  localparam logic [c_CB-1:0] c_SIZE_M1 = c_CB'(SPRITE_SIZE - 1);
  localparam logic [c_FB-1:0] c_F_LAST  = c_FB'(FRAME_COUNT - 1);
  localparam logic [c_TW-1:0] c_T_LAST  = c_TW'(FRAME_TIME - 1);
  localparam logic [2:0]      c_COLOR   = 3'(PRIMARY_COLOR);

  logic [10:0]     w_sh, w_sv, w_xp, w_yp;
  logic            w_hit;
  logic [c_CB-1:0] w_dx, w_dy, w_xcol;

  logic [c_CB-1:0] r_xin, r_yin;
  logic            r_hit_q;
  logic [2:0]      r_rgb;
  logic            r_active;
  logic [c_TW-1:0] r_tcnt;
  logic [c_FB-1:0] r_frame;
  logic            r_done;

  // 11-bit compare keeps a sprite near the right/bottom edge from wrapping to 0
  assign w_sh  = {1'b0, sif.shpos};
  assign w_sv  = {1'b0, sif.svpos};
  assign w_xp  = {1'b0, sif.xpos};
  assign w_yp  = {1'b0, sif.ypos};
  assign w_hit = (w_sh >= w_xp) && (w_sh < w_xp + 11'(SPRITE_SIZE)) &&
                 (w_sv >= w_yp) && (w_sv < w_yp + 11'(SPRITE_SIZE));

  assign w_dx = sif.shpos[c_CB-1:0] - sif.xpos[c_CB-1:0];
  assign w_dy = sif.svpos[c_CB-1:0] - sif.ypos[c_CB-1:0];

`ifdef SPRITE_HFLIP_EN
  assign w_xcol = sif.hflip ? (c_SIZE_M1 - w_dx) : w_dx;
`else
  assign w_xcol = w_dx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xin    <= '0;
      r_yin    <= '0;
      r_hit_q  <= 1'b0;
      r_rgb    <= 3'd0;
      r_active <= 1'b0;
    end else begin
      r_hit_q <= w_hit;
      if (w_hit) begin
        r_xin <= w_xcol;
        r_yin <= w_dy;
      end
      r_active <= r_hit_q & sif.pixel;
      r_rgb    <= (r_hit_q & sif.pixel) ? c_COLOR : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sif.anim_restart) begin
      r_tcnt  <= '0;
      r_frame <= '0;
      r_done  <= 1'b0;
    end else if (!r_done && sif.anim_en && sif.vsync) begin
      if (r_tcnt != c_T_LAST) begin
        r_tcnt <= r_tcnt + 1'b1;
      end else begin
        r_tcnt <= '0;
        if (r_frame != c_F_LAST)
          r_frame <= r_frame + 1'b1;
        else if (sif.oneshot)
          r_done <= 1'b1;
        else
          r_frame <= '0;
      end
    end
  end

  assign sif.frame     = r_frame;
  assign sif.yin       = r_yin;
  assign sif.xin       = r_xin;
  assign sif.rgb       = r_rgb;
  assign sif.active    = r_active;
  assign sif.anim_done = r_done;
endmodule

`default_nettype wire

// File: tb/tb_animated_sprite_gen.sv
// ============================================================================
// Module      : tb_animated_sprite_gen
// Description : Directed and randomized bench for animated_sprite_gen against
//               a tick-count reference model. Honors SPRITE_HFLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_animated_sprite_gen;
  localparam int SIZE = 16;
  localparam int FC   = 3;
  localparam int FT   = 2;
  localparam int PC   = 5;
  localparam int CB   = 4;
  localparam int FB   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  animated_sprite_gen_if #(.SPRITE_SIZE(SIZE), .FRAME_COUNT(FC)) sif ();

  animated_sprite_gen #(
    .SPRITE_SIZE(SIZE), .FRAME_COUNT(FC), .FRAME_TIME(FT), .PRIMARY_COLOR(PC)
  ) dut (
    .clk(clk), .reset(reset), .sif(sif)
  );

  logic rom [0:(1 << (FB + 2*CB)) - 1];
  logic force_en, force_val;
  logic flip;
  assign sif.pixel = force_en ? force_val : rom[{sif.frame, sif.yin, sif.xin}];
`ifdef SPRITE_HFLIP_EN
  assign sif.hflip = flip;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: animation tracked as effective ticks since restart
  int m_xin, m_yin, m_rgb, m_count;
  bit m_hitq, m_active, m_done;

  function automatic int exp_frame();
    return m_done ? FC - 1 : (m_count / FT) % FC;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    bit pix, hit;
    int dx, dy;
    logic [FB+2*CB-1:0] idx;
    idx = {FB'(exp_frame()), CB'(m_yin), CB'(m_xin)};
    pix = force_en ? force_val : rom[idx];
    if (reset) begin
      m_xin = 0; m_yin = 0; m_rgb = 0; m_count = 0;
      m_hitq = 0; m_active = 0; m_done = 0;
    end else begin
      m_active = m_hitq && pix;
      m_rgb    = m_active ? PC : 0;
      dx  = int'(sif.shpos) - int'(sif.xpos);
      dy  = int'(sif.svpos) - int'(sif.ypos);
      hit = dx >= 0 && dx < SIZE && dy >= 0 && dy < SIZE;
      m_hitq = hit;
      if (hit) begin
        m_yin = dy;
`ifdef SPRITE_HFLIP_EN
        m_xin = flip ? SIZE - 1 - dx : dx;
`else
        m_xin = dx;
`endif
      end
      if (sif.anim_restart) begin
        m_count = 0;
        m_done  = 0;
      end else if (!m_done && sif.anim_en && sif.vsync) begin
        m_count++;
        if (sif.oneshot && (m_count % (FT * FC)) == 0) m_done = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("frame", 32'(sif.frame), 32'(exp_frame()));
    check("xin", 32'(sif.xin), 32'(m_xin));
    check("yin", 32'(sif.yin), 32'(m_yin));
    check("rgb", 32'(sif.rgb), 32'(m_rgb));
    check("active", 32'(sif.active), 32'(m_active));
    check("anim_done", 32'(sif.anim_done), 32'(m_done));
  endtask

  task automatic beam(input int h, input int v);
    sif.shpos = 10'(h);
    sif.svpos = 10'(v);
  endtask

  task automatic vs_pulse();
    sif.vsync = 1'b1;
    step();
    sif.vsync = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << (FB + 2*CB)); i++) rom[i] = 1'($urandom);
    force_en = 1'b0; force_val = 1'b0; flip = 1'b0;
    sif.xpos = 10'd100; sif.ypos = 10'd50;
    beam(0, 0);
    sif.vsync = 1'b0; sif.anim_en = 1'b0; sif.anim_restart = 1'b0; sif.oneshot = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("rst_rgb", 32'(sif.rgb), 32'd0);
    check("rst_frame", 32'(sif.frame), 32'd0);
    reset = 1'b0;

    // Window corners and just-outside columns
    beam(100, 50);  step();
    check("corner_lo_xin", 32'(sif.xin), 32'd0);
    check("corner_lo_yin", 32'(sif.yin), 32'd0);
    beam(115, 65);  step();
    check("corner_hi_xin", 32'(sif.xin), 32'd15);
    check("corner_hi_yin", 32'(sif.yin), 32'd15);
    beam(116, 50);  step();
    beam(99, 50);   step(); step();
    check("miss_rgb", 32'(sif.rgb), 32'd0);

    // Forced pixel: colour appears exactly two clocks after entry
    force_en = 1'b1; force_val = 1'b1;
    beam(0, 0);     step(); step();
    beam(105, 55);  step();
    check("lat1_rgb", 32'(sif.rgb), 32'd0);
    step();
    check("lat2_rgb", 32'(sif.rgb), 32'(PC));
    check("lat2_active", 32'(sif.active), 32'd1);
    force_val = 1'b0; step(); step();
    check("pix0_rgb", 32'(sif.rgb), 32'd0);
    force_en = 1'b0;

    // Right screen edge: no wrap to shpos=0
    sif.xpos = 10'd1020;
`ifdef SPRITE_HFLIP_EN
    flip = 1'b1;
`endif
    beam(1023, 50); step();
    check("edge_xin", 32'(sif.xin), flip ? 32'd12 : 32'd3);
    beam(0, 50);    step(); step();
    check("edge_nowrap", 32'(sif.rgb), 32'd0);
    flip = 1'b0;

    // One-shot run: stops on last frame, sticky, restart clears
    sif.anim_en = 1'b1; sif.oneshot = 1'b1;
    sif.anim_restart = 1'b1; step(); sif.anim_restart = 1'b0;
    for (int i = 0; i < FT * FC; i++) vs_pulse();
    check("os_frame", 32'(sif.frame), 32'(FC - 1));
    check("os_done", 32'(sif.anim_done), 32'd1);
    sif.oneshot = 1'b0;
    for (int i = 0; i < 4; i++) vs_pulse();
    check("os_sticky", 32'(sif.anim_done), 32'd1);
    sif.anim_restart = 1'b1; sif.vsync = 1'b1; step();
    sif.anim_restart = 1'b0; sif.vsync = 1'b0;
    check("restart_frame", 32'(sif.frame), 32'd0);
    check("restart_done", 32'(sif.anim_done), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int h, v;
      if (n % 500 == 0) begin
        sif.xpos = 10'($urandom);
        sif.ypos = 10'($urandom);
        sif.oneshot = 1'($urandom);
      end
      h = int'(sif.xpos) - 4 + int'($urandom_range(0, SIZE + 8));
      v = int'(sif.ypos) - 4 + int'($urandom_range(0, SIZE + 8));
      h = (h < 0) ? 0 : (h > 1023) ? 1023 : h;
      v = (v < 0) ? 0 : (v > 1023) ? 1023 : v;
      beam(h, v);
      sif.vsync        = ($urandom_range(0, 3) == 0);
      sif.anim_en      = ($urandom_range(0, 9) != 0);
      sif.anim_restart = ($urandom_range(0, 99) < 2);
      reset            = ($urandom_range(0, 199) == 0);
      flip             = 1'($urandom);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/animated_sprite_gen.md
# animated_sprite_gen

Parametrised animated sprite renderer for the raster video pipeline. It compares the beam position against the sprite's screen position and drives frame, row and column addresses to an external sprite ROM. It then turns the ROM's pixel bit into a 3-bit colour with a transparency flag. On top of looping animation it adds configurable sprite size and frame count, animation enable, restart, one-shot mode with a done flag, and an optional horizontal mirror.

## Interface
- SPRITE_SIZE, 16: sprite width/height in pixels; power of two, 2..64.
- FRAME_COUNT, 2: number of animation frames, ≥1.
- FRAME_TIME, 30: vsync pulses per frame, ≥1.
- PRIMARY_COLOR, 1: 3-bit colour driven for set pixels.
- Derived widths: CB = $clog2(SPRITE_SIZE); FB = max(1, $clog2(FRAME_COUNT)).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- shpos  in  10  beam horizontal position.
- svpos  in  10  beam vertical position.
- xpos  in  10  sprite left edge.
- ypos  in  10  sprite top edge.
- vsync  in  1  one-cycle frame tick.
- anim_en  in  1  1 = animation counters run.
- anim_restart  in  1  pulse; restart at frame 0.
- oneshot  in  1  1 = stop on last frame instead of wrapping.
- hflip  in  1  mirror columns; present only with SPRITE_HFLIP_EN.
- frame  out  FB  ROM frame address.
- yin  out  CB  ROM row address.
- xin  out  CB  ROM column address.
- pixel  in  1  ROM data; combinational from {frame, yin, xin}.
- rgb  out  3  colour, 0 when transparent or outside sprite.
- active  out  1  sprite pixel opaque this cycle; for priority muxing.
- anim_done  out  1  one-shot animation finished; sticky.

## Operation
- Window test: dx = shpos − xpos and dy = svpos − ypos, computed at 11 bits.
- hit = (shpos ≥ xpos) & (shpos < xpos+SPRITE_SIZE) & (svpos ≥ ypos) & (svpos < ypos+SPRITE_SIZE). Compare at 11 bits so that xpos+SIZE > 1023 does not wrap. Both edges are inclusive on the low side.
- Stage 1 register, on hit:
  - yin ← dy[CB-1:0].
  - xin ← dx[CB-1:0], or SPRITE_SIZE−1−dx when mirrored.
  - hit_q ← hit.
  - On miss: xin and yin hold their values; hit_q ← 0.
- Stage 2 register: active ← hit_q & pixel; rgb ← (hit_q & pixel) ? PRIMARY_COLOR : 0.
- Animation: tick counter tcnt (0..FRAME_TIME−1) and frame counter. Priority per edge:
  1. reset: tcnt, frame and anim_done all cleared.
  2. anim_restart: tcnt=0, frame=0, anim_done=0. A vsync on the same cycle is ignored.
  3. anim_done=1: everything frozen.
  4. anim_en & vsync, tcnt < FRAME_TIME−1: tcnt+1.
  5. anim_en & vsync, tcnt = FRAME_TIME−1: tcnt=0, then:
     - frame < FRAME_COUNT−1: frame+1.
     - last frame, oneshot=0: frame=0.
     - last frame, oneshot=1: frame holds, anim_done ← 1.
- anim_en=0: counters hold; pixel path keeps running.
- FRAME_COUNT=1: frame is constant 0. In one-shot mode anim_done sets after FRAME_TIME ticks.
- Clearing oneshot while anim_done=1 does not resume the animation; only anim_restart or reset does.

## Timing
- Reset values: frame, yin, xin, rgb, active, anim_done all 0; internal hit_q=0, tcnt=0.
- Beam position in cycle n gives xin/yin valid in cycle n+1 and rgb/active valid in cycle n+2. Total latency is 2 clocks; the upstream timing generator compensates.
- frame changes only on the edge that consumes the expiring vsync. It is stable for the whole scanline set between vsyncs.
- anim_done rises on the same edge that would otherwise have wrapped the frame.
- Reset asserted mid-sprite: rgb is 0 from the next edge and for one further cycle (hit_q cleared).

## Configuration
- SPRITE_HFLIP_EN defined:
  - hflip port exists.
  - hflip is sampled with the pixel in stage 1, so flipping takes effect per pixel.
  - hflip=1 gives xin = SPRITE_SIZE−1−dx.
- Undefined: no hflip port; xin = dx always.

## Test plan
- SIZE=16, xpos=100, ypos=50, beam at (100,50) then (115,65): xin/yin = 0/0 and 15/15 one cycle later; beam at (116,50) or (99,50) keeps hit_q=0 and rgb=0 two cycles later.
- pixel tied to 1 and PRIMARY_COLOR=5 inside the window: rgb=5 and active=1 exactly 2 clocks after the beam enters; pixel=0 gives rgb=0, active=0.
- FRAME_TIME=3, FRAME_COUNT=2, loop mode, anim_en=1, 12 vsync pulses: frame sequence 0,0,0,1,1,1,0,0,0,1,1,1.
- oneshot=1, FRAME_TIME=2, FRAME_COUNT=3, 6 vsyncs: frame ends at 2 with anim_done=1; further vsyncs leave it unchanged; anim_restart returns frame=0, done=0.
- anim_restart and vsync in the same cycle at tcnt=FRAME_TIME−1: tcnt=0, frame=0; anim_en=0 with vsyncs: no change.
- xpos=1020, SIZE=16, beam at 1023: hit with xin=3, no wrap to a hit at shpos=0. With SPRITE_HFLIP_EN and hflip=1: xin=12.
